// File: rtl/i2c_bus_arbiter_if.sv
// Command/handshake bundle between i2c_bus_arbiter (master side) and one uii2c instance (slave side).
interface i2c_bus_arbiter_if;
  logic        iic_en;
  logic [31:0] iic_wr_data;
  logic [7:0]  iic_wr_cnt;
  logic [7:0]  iic_rd_cnt;
  logic        iic_mode;
  logic        iic_busy;
  logic [7:0]  iic_rd_data;

  modport master (
    output iic_en,
    output iic_wr_data,
    output iic_wr_cnt,
    output iic_rd_cnt,
    output iic_mode,
    input  iic_busy,
    input  iic_rd_data
  );

  modport slave (
    input  iic_en,
    input  iic_wr_data,
    input  iic_wr_cnt,
    input  iic_rd_cnt,
    input  iic_mode,
    output iic_busy,
    output iic_rd_data
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one uii2c master between NREQ requesters.
// Optional transaction watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int          NREQ      = 2,
  parameter int unsigned TO_CYCLES = 2000000
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_wr_data,
  input  logic [8*NREQ-1:0]    req_wr_cnt,
  input  logic [8*NREQ-1:0]    req_rd_cnt,
  input  logic [NREQ-1:0]      req_mode,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [7:0]           rd_data_o,
  i2c_bus_arbiter_if.master    iic
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || TO_CYCLES == 0) begin : g_bad_param
    $error("i2c_bus_arbiter: NREQ must be 2..4 and TO_CYCLES nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_reg;
  logic [PW-1:0] ptr_reg;

  logic [31:0] wr_data_arr [NREQ];
  logic [7:0]  wr_cnt_arr  [NREQ];
  logic [7:0]  rd_cnt_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    assign wr_data_arr[gi] = req_wr_data[32*gi +: 32];
    assign wr_cnt_arr[gi]  = req_wr_cnt[8*gi +: 8];
    assign rd_cnt_arr[gi]  = req_rd_cnt[8*gi +: 8];
  end

  // Search upward from the pointer with wrap-around; first asserted request wins.
  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [PW:0]     cand;
  logic [PW-1:0]   ptr_next;

  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_reg} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!win_valid && req[cand[PW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TO_CYCLES - 1);
  logic [31:0] timer_reg;
  logic        err_reg;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      ptr_reg         <= '0;
      gnt             <= '0;
      done            <= '0;
      rd_data_o       <= '0;
      iic.iic_en      <= 1'b0;
      iic.iic_wr_data <= '0;
      iic.iic_wr_cnt  <= '0;
      iic.iic_rd_cnt  <= '0;
      iic.iic_mode    <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      timer_reg       <= '0;
      err_reg         <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      err_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          // A busy bus here is a transfer we no longer own (reset or timeout abort).
          if (|req && !iic.iic_busy) begin
            state_reg <= S_ARB;
          end
        end

        S_ARB: begin
`ifdef I2C_ARB_TIMEOUT_EN
          timer_reg <= '0;
`endif
          if (win_valid) begin
            gnt             <= win_onehot;
            iic.iic_wr_data <= wr_data_arr[win_idx];
            iic.iic_wr_cnt  <= wr_cnt_arr[win_idx];
            iic.iic_rd_cnt  <= rd_cnt_arr[win_idx];
            iic.iic_mode    <= req_mode[win_idx];
            iic.iic_en      <= 1'b1;
            ptr_reg         <= ptr_next;
            state_reg       <= S_START;
          end else begin
            state_reg <= S_IDLE;
          end
        end

        S_START, S_RUN: begin
`ifdef I2C_ARB_TIMEOUT_EN
          timer_reg <= timer_reg + 32'd1;
          if (timer_reg == TO_LAST) begin
            iic.iic_en <= 1'b0;
            done       <= gnt;
            err_reg    <= 1'b1;
            state_reg  <= S_DONE;
          end else
`endif
          if (state_reg == S_START) begin
            if (iic.iic_busy) begin
              iic.iic_en <= 1'b0;
              state_reg  <= S_RUN;
            end
          end else if (!iic.iic_busy) begin
            rd_data_o <= iic.iic_rd_data;
            done      <= gnt;
            state_reg <= S_DONE;
          end
        end

        S_DONE: begin
          gnt       <= '0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter with a behavioural uii2c responder and an expected-transaction queue.
module tb_i2c_bus_arbiter;
  localparam int NREQ = 2;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [32*NREQ-1:0] req_wr_data = '0;
  logic [8*NREQ-1:0] req_wr_cnt = '0;
  logic [8*NREQ-1:0] req_rd_cnt = '0;
  logic [NREQ-1:0]   req_mode = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [7:0]        rd_data_o;

  i2c_bus_arbiter_if iic_bus();

  i2c_bus_arbiter #(.NREQ(NREQ), .TO_CYCLES(100)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .req         (req),
    .req_wr_data (req_wr_data),
    .req_wr_cnt  (req_wr_cnt),
    .req_rd_cnt  (req_rd_cnt),
    .req_mode    (req_mode),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .rd_data_o   (rd_data_o),
    .iic         (iic_bus)
  );

  always #5 clk_i = ~clk_i;

  // uii2c responder: raises busy one half-cycle after seeing iic_en, holds it model_len cycles.
  logic            model_busy = 1'b0;
  logic            force_busy = 1'b0;
  logic            model_respond = 1'b1;
  int              model_len = 20;
  int              busy_left = 0;
  logic [7:0]      model_rd = 8'h00;
  logic [7:0]      rd_byte = 8'h00;
  logic [NREQ-1:0] cap_gnt = '0;
  logic [31:0]     cap_wd = '0;
  logic [7:0]      cap_wc = '0;
  logic [7:0]      cap_rc = '0;
  logic            cap_mode = 1'b0;
  logic            en_late = 1'b0;

  assign iic_bus.iic_busy    = model_busy | force_busy;
  assign iic_bus.iic_rd_data = rd_byte;

  always @(negedge clk_i) begin
    if (!model_busy) begin
      if (iic_bus.iic_en && model_respond) begin
        model_busy = 1'b1;
        busy_left  = model_len;
        cap_gnt    = gnt;
        cap_wd     = iic_bus.iic_wr_data;
        cap_wc     = iic_bus.iic_wr_cnt;
        cap_rc     = iic_bus.iic_rd_cnt;
        cap_mode   = iic_bus.iic_mode;
        en_late    = 1'b0;
      end
    end else begin
      if (iic_bus.iic_en) en_late = 1'b1;
      busy_left--;
      if (busy_left == 0) begin
        model_busy = 1'b0;
        rd_byte    = model_rd;
      end
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] wd;
    logic [7:0]  wc;
    logic [7:0]  rc;
    logic        mode;
    logic [7:0]  rd;
    logic        er;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  task automatic set_slot(input int k, input logic [31:0] wd, input logic [7:0] wc,
                          input logic [7:0] rc, input logic m);
    req_wr_data[32*k +: 32] = wd;
    req_wr_cnt[8*k +: 8]    = wc;
    req_rd_cnt[8*k +: 8]    = rc;
    req_mode[k]             = m;
  endtask

  task automatic push_exp(input int k, input logic [31:0] wd, input logic [7:0] wc,
                          input logic [7:0] rc, input logic m, input logic [7:0] rd, input logic er);
    exp_t x;
    x.idx = k; x.wd = wd; x.wc = wc; x.rc = rc; x.mode = m; x.rd = rd; x.er = er;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_i);
      if (done !== '0) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({gnt, done, err} !== '0) $display("FAIL reset_outputs: got %b, expected 0", {gnt, done, err});
    else passes++;
    checks++;
    if ({iic_bus.iic_en, iic_bus.iic_mode} !== 2'b00)
      $display("FAIL reset_en_mode: got %b, expected 00", {iic_bus.iic_en, iic_bus.iic_mode});
    else passes++;
    checks++;
    if ({iic_bus.iic_wr_data, iic_bus.iic_wr_cnt, iic_bus.iic_rd_cnt, rd_data_o} !== 56'd0)
      $display("FAIL reset_cmd_regs: got %h, expected 0",
               {iic_bus.iic_wr_data, iic_bus.iic_wr_cnt, iic_bus.iic_rd_cnt, rd_data_o});
    else passes++;
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_write();
    int   lat;
    logic found;
    set_slot(0, 32'h0830_0878, 8'd4, 8'd0, 1'b0);
    model_len = 40;
    push_exp(0, 32'h0830_0878, 8'd4, 8'd0, 1'b0, 8'h00, 1'b0);
    req[0] = 1'b1;
    lat = 0;
    while (!iic_bus.iic_en && lat < 10) begin
      @(negedge clk_i);
      lat++;
    end
    checks++;
    if (lat !== 2) $display("FAIL write_latency: got %0d cycles, expected 2", lat);
    else passes++;
    wait_done(200, found);
    req = req & ~done;
    e = exp_q.pop_front();
    checks++;
    if (!found) $display("FAIL write_done_seen: got none, expected done within 200 cycles");
    else passes++;
    checks++;
    if (done !== NREQ'(1) << e.idx || err !== e.er)
      $display("FAIL write_done_err: got done=%b err=%b, expected done=%b err=%b", done, err, NREQ'(1) << e.idx, e.er);
    else passes++;
    checks++;
    if (cap_gnt !== NREQ'(1) << e.idx || cap_wd !== e.wd || cap_wc !== e.wc || cap_mode !== e.mode)
      $display("FAIL write_cmd: got gnt=%b wd=%h wc=%0d mode=%b, expected gnt=%b wd=%h wc=%0d mode=%b",
               cap_gnt, cap_wd, cap_wc, cap_mode, NREQ'(1) << e.idx, e.wd, e.wc, e.mode);
    else passes++;
    checks++;
    if (en_late !== 1'b0) $display("FAIL write_en_drop: got iic_en high while busy, expected low");
    else passes++;
    @(negedge clk_i);
    checks++;
    if ({done, gnt} !== '0) $display("FAIL write_single_pulse: got done/gnt=%b, expected 0", {done, gnt});
    else passes++;
  endtask

  task automatic test_contention();
    logic found;
    rst_n = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
    model_len = 10;
    set_slot(0, 32'hA0A0_0001, 8'd2, 8'd0, 1'b0);
    set_slot(1, 32'hB1B1_0002, 8'd3, 8'd0, 1'b0);
    push_exp(0, 32'hA0A0_0001, 8'd2, 8'd0, 1'b0, 8'h00, 1'b0);
    push_exp(1, 32'hB1B1_0002, 8'd3, 8'd0, 1'b0, 8'h00, 1'b0);
    req = 2'b11;
    for (int n = 0; n < 2; n++) begin
      wait_done(100, found);
      e = exp_q.pop_front();
      checks++;
      if (!found || done !== NREQ'(1) << e.idx || cap_wd !== e.wd)
        $display("FAIL contention_%0d: got done=%b wd=%h, expected done=%b wd=%h", n, done, cap_wd, NREQ'(1) << e.idx, e.wd);
      else passes++;
      req = req & ~done;
    end
    for (int n = 0; n < 4; n++) push_exp(n % 2, (n % 2 == 0) ? 32'hA0A0_0001 : 32'hB1B1_0002,
                                          (n % 2 == 0) ? 8'd2 : 8'd3, 8'd0, 1'b0, 8'h00, 1'b0);
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_done(100, found);
      e = exp_q.pop_front();
      checks++;
      if (!found || done !== NREQ'(1) << e.idx || cap_wd !== e.wd || cap_wc !== e.wc)
        $display("FAIL alternate_%0d: got done=%b wd=%h wc=%0d, expected done=%b wd=%h wc=%0d",
                 n, done, cap_wd, cap_wc, NREQ'(1) << e.idx, e.wd, e.wc);
      else passes++;
    end
    req = '0;
    @(negedge clk_i);
  endtask

  task automatic test_read();
    logic found;
    set_slot(1, 32'h0078_3A00, 8'd3, 8'd1, 1'b1);
    model_rd = 8'h56;
    push_exp(1, 32'h0078_3A00, 8'd3, 8'd1, 1'b1, 8'h56, 1'b0);
    req[1] = 1'b1;
    wait_done(100, found);
    req = req & ~done;
    e = exp_q.pop_front();
    checks++;
    if (!found || done !== NREQ'(1) << e.idx || rd_data_o !== e.rd || err !== e.er)
      $display("FAIL read_data: got done=%b rd=%h err=%b, expected done=%b rd=%h err=%b",
               done, rd_data_o, err, NREQ'(1) << e.idx, e.rd, e.er);
    else passes++;
    checks++;
    if (cap_mode !== e.mode || cap_wc !== e.wc || cap_rc !== e.rc)
      $display("FAIL read_cmd: got mode=%b wc=%0d rc=%0d, expected mode=%b wc=%0d rc=%0d",
               cap_mode, cap_wc, cap_rc, e.mode, e.wc, e.rc);
    else passes++;
    @(negedge clk_i);
  endtask

  task automatic test_withdraw();
    logic found;
    logic regrant;
    set_slot(0, 32'h1234_5678, 8'd4, 8'd0, 1'b0);
    push_exp(0, 32'h1234_5678, 8'd4, 8'd0, 1'b0, 8'h00, 1'b0);
    req[0] = 1'b1;
    for (int i = 0; i < 20 && !model_busy; i++) @(negedge clk_i);
    repeat (3) @(negedge clk_i);
    req[0] = 1'b0;
    wait_done(100, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || done !== NREQ'(1) << e.idx)
      $display("FAIL withdraw_done: got done=%b, expected %b", done, NREQ'(1) << e.idx);
    else passes++;
    regrant = 1'b0;
    repeat (50) begin
      @(negedge clk_i);
      if (gnt !== '0 || iic_bus.iic_en !== 1'b0) regrant = 1'b1;
    end
    checks++;
    if (regrant !== 1'b0) $display("FAIL withdraw_no_regrant: got a second grant, expected none");
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic found;
    set_slot(0, 32'hC0C0_0010, 8'd2, 8'd0, 1'b0);
    set_slot(1, 32'hD1D1_0020, 8'd2, 8'd0, 1'b0);
    push_exp(0, 32'hC0C0_0010, 8'd2, 8'd0, 1'b0, 8'h00, 1'b0);
    req[0] = 1'b1;
    for (int i = 0; i < 20 && !model_busy; i++) @(negedge clk_i);
    req[1] = 1'b1;
    push_exp(1, 32'hD1D1_0020, 8'd2, 8'd0, 1'b0, 8'h00, 1'b0);
    push_exp(0, 32'hC0C0_0010, 8'd2, 8'd0, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 3; n++) begin
      wait_done(100, found);
      e = exp_q.pop_front();
      checks++;
      if (!found || done !== NREQ'(1) << e.idx || cap_wd !== e.wd)
        $display("FAIL b2b_%0d: got done=%b wd=%h, expected done=%b wd=%h", n, done, cap_wd, NREQ'(1) << e.idx, e.wd);
      else passes++;
      if (n == 1) req[1] = 1'b0;
      if (n == 2) req[0] = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic test_async_reset();
    logic found;
    logic early;
    model_respond = 1'b0;
    set_slot(0, 32'h5555_AAAA, 8'd4, 8'd0, 1'b0);
    req[0] = 1'b1;
    for (int i = 0; i < 20 && !iic_bus.iic_en; i++) @(negedge clk_i);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (iic_bus.iic_en !== 1'b0 || gnt !== '0)
      $display("FAIL async_reset: got en=%b gnt=%b, expected en=0 gnt=0", iic_bus.iic_en, gnt);
    else passes++;
    force_busy = 1'b1;
    @(negedge clk_i);
    rst_n = 1'b1;
    early = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      if (gnt !== '0 || iic_bus.iic_en !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) $display("FAIL busy_hold: got grant while bus busy, expected none");
    else passes++;
    push_exp(0, 32'h5555_AAAA, 8'd4, 8'd0, 1'b0, 8'h00, 1'b0);
    model_respond = 1'b1;
    force_busy    = 1'b0;
    wait_done(100, found);
    req = req & ~done;
    e = exp_q.pop_front();
    checks++;
    if (!found || done !== NREQ'(1) << e.idx || cap_wd !== e.wd)
      $display("FAIL after_reset_done: got done=%b wd=%h, expected done=%b wd=%h", done, cap_wd, NREQ'(1) << e.idx, e.wd);
    else passes++;
    @(negedge clk_i);
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    model_respond = 1'b0;
    set_slot(0, 32'hDEAD_BEEF, 8'd4, 8'd0, 1'b0);
    push_exp(0, 32'hDEAD_BEEF, 8'd4, 8'd0, 1'b0, 8'h00, 1'b1);
    req[0] = 1'b1;
    for (int i = 0; i < 20 && gnt === '0; i++) @(negedge clk_i);
    cnt = 0;
    while (done === '0 && cnt < 300) begin
      @(negedge clk_i);
      cnt++;
    end
    e = exp_q.pop_front();
    checks++;
    if (cnt !== 100) $display("FAIL timeout_cycles: got %0d, expected 100", cnt);
    else passes++;
    checks++;
    if (done !== NREQ'(1) << e.idx || err !== e.er || iic_bus.iic_en !== 1'b0)
      $display("FAIL timeout_flags: got done=%b err=%b en=%b, expected done=%b err=%b en=0",
               done, err, iic_bus.iic_en, NREQ'(1) << e.idx, e.er);
    else passes++;
    req[0] = 1'b0;
    model_respond = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_read();
    test_withdraw();
    test_back_to_back();
    test_async_reset();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 time units, expected finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
